// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable almost flags, optional
// first-word-fall-through read, synchronous flush and sticky error flags.
module fifo_param #(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic [DATA_W-1:0]          inp_data,
    output logic [DATA_W-1:0]          out_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     cur_size,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop_ok;
    logic              push_ok;

    // Handshake: pop is taken only when data is held; push is taken when a
    // slot is free or one is being freed by an accepted pop on the same edge.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count <= CNT_W'(AE_LEVEL));
    assign cur_size     = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)
                count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok)
                count <= count - CNT_W'(1);
        end
    end

    // A new error event on the same edge as clr_err wins, so the flag stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clr_err) | (~flush & push & ~push_ok);
            underflow <= (underflow & ~clr_err) | (~flush & pop  & ~pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push_ok)
            mem[wr_ptr] <= inp_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign out_data = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg_read
            logic [DATA_W-1:0] out_reg;
            always_ff @(posedge clk) begin
                if (reset)
                    out_reg <= '0;
                else if (!flush && pop_ok)
                    out_reg <= mem[rd_ptr];
            end
            assign out_data = out_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: registered-read and FWFT instances share one
// stimulus stream so occupancy/flags must agree while read data differs by mode.
module tb_fifo_param;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic              pop;
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] inp_data;

    logic [DATA_W-1:0] out0, out1;
    logic              empty0, full0, af0, ae0, ovf0, unf0;
    logic              empty1, full1, af1, ae1, ovf1, unf1;
    logic [CNT_W-1:0]  size0, size1;

    int compared   = 0;
    int mismatched = 0;

    fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_dut0 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .inp_data(inp_data), .out_data(out0), .empty(empty0), .full(full0),
        .almost_full(af0), .almost_empty(ae0), .cur_size(size0),
        .overflow(ovf0), .underflow(unf0)
    );

    fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_dut1 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
        .inp_data(inp_data), .out_data(out1), .empty(empty1), .full(full1),
        .almost_full(af1), .almost_empty(ae1), .cur_size(size1),
        .overflow(ovf1), .underflow(unf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Occupancy and flags of both instances against one expected size.
    task automatic check_size(input string tag, input int exp_size);
        check({tag, " size0"}, 32'(size0), 32'(exp_size));
        check({tag, " size1"}, 32'(size1), 32'(exp_size));
        check({tag, " empty"}, {30'd0, empty0, empty1}, (exp_size == 0) ? 32'd3 : 32'd0);
        check({tag, " full"}, {30'd0, full0, full1}, (exp_size == DEPTH) ? 32'd3 : 32'd0);
        check({tag, " af"}, {30'd0, af0, af1}, (exp_size >= 12) ? 32'd3 : 32'd0);
        check({tag, " ae"}, {30'd0, ae0, ae1}, (exp_size <= 4) ? 32'd3 : 32'd0);
    endtask

    task automatic check_err(input string tag, input logic exp_ovf, input logic exp_unf);
        check({tag, " overflow"}, {30'd0, ovf0, ovf1}, {30'd0, exp_ovf, exp_ovf});
        check({tag, " underflow"}, {30'd0, unf0, unf1}, {30'd0, exp_unf, exp_unf});
    endtask

    // Drive one edge's worth of controls, then sample 1 time unit after it.
    task automatic cyc(input logic do_push, input logic do_pop, input logic [DATA_W-1:0] d,
                       input logic do_flush = 1'b0, input logic do_clr = 1'b0,
                       input logic do_reset = 1'b0);
        push     = do_push;
        pop      = do_pop;
        inp_data = d;
        flush    = do_flush;
        clr_err  = do_clr;
        reset    = do_reset;
        @(posedge clk);
        #1;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        clr_err  = 1'b0;
        reset    = 1'b0;
        inp_data = $urandom_range(0, 1023);
    endtask

    initial begin
        push = 0; pop = 0; flush = 0; clr_err = 0; reset = 1; inp_data = '0;

        // Reset state
        cyc(1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b1);
        check_size("reset", 0);
        check_err("reset", 1'b0, 1'b0);
        check("reset out0", 32'(out0), 32'h0);
        check("reset out1", 32'(out1), 32'h0);

        // 1: almost_empty boundary
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 10'(i));
        check_size("t1 four", 4);
        check("t1 fwft head", 32'(out1), 32'h001);
        cyc(1'b1, 1'b0, 10'h005);
        check_size("t1 five", 5);

        // 2: fill, almost_full boundary, overflow, drain, underflow
        for (int i = 6; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 10'(i));
            check_size($sformatf("t2 fill%0d", i), i);
        end
        cyc(1'b1, 1'b0, 10'h3FF);
        check_size("t2 ovf", 16);
        check_err("t2 ovf", 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, '0);
            check($sformatf("t2 pop%0d out0", i), 32'(out0), 32'(i));
            check($sformatf("t2 pop%0d out1", i), 32'(out1), (i < 16) ? 32'(i + 1) : 32'h0);
            check($sformatf("t2 pop%0d size", i), 32'(size0), 32'(16 - i));
        end
        check_size("t2 drained", 0);
        cyc(1'b0, 1'b1, '0);
        check_err("t2 unf", 1'b1, 1'b1);
        check("t2 unf out0 holds", 32'(out0), 32'h010);
        check("t2 unf out1", 32'(out1), 32'h0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_err("t2 clr", 1'b0, 1'b0);

        // 3: wrap and simultaneous push/pop while full
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 10'(32'h020 + i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, '0);
        check("t3 out0 0x029", 32'(out0), 32'h029);
        check_size("t3 empty", 0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 10'(32'h100 + i));
        check_size("t3 full", 16);
        check("t3 fwft head", 32'(out1), 32'h100);
        cyc(1'b1, 1'b1, 10'h2AA);
        check("t3 sim out0", 32'(out0), 32'h100);
        check("t3 sim out1", 32'(out1), 32'h101);
        check_size("t3 sim", 16);
        check_err("t3 sim", 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, '0);
            check($sformatf("t3 drain%0d", i), 32'(out0), (i < 16) ? 32'(32'h100 + i) : 32'h2AA);
        end
        check_size("t3 drained", 0);

        // 4: FWFT latency and empty push+pop
        cyc(1'b1, 1'b0, 10'h055);
        check("t4 fwft lat", 32'(out1), 32'h055);
        check("t4 out0 holds", 32'(out0), 32'h2AA);
        cyc(1'b0, 1'b1, '0);
        check("t4 pop out1", 32'(out1), 32'h0);
        check("t4 pop out0", 32'(out0), 32'h055);
        check_size("t4 pop", 0);
        cyc(1'b1, 1'b1, 10'h077);
        check_size("t4 pp empty", 1);
        check_err("t4 pp empty", 1'b0, 1'b1);
        check("t4 pp out1", 32'(out1), 32'h077);
        check("t4 pp out0", 32'(out0), 32'h055);

        // 5: flush, clr_err, clr_err colliding with an overflow
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 10'(32'h0A0 + i));
        check_size("t5 seven", 7);
        cyc(1'b1, 1'b1, 10'h1FF, 1'b1);
        check_size("t5 flush", 0);
        check_err("t5 flush", 1'b0, 1'b1);
        check("t5 flush out0", 32'(out0), 32'h055);
        check("t5 flush out1", 32'(out1), 32'h0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_err("t5 clr unf", 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 10'(32'h0C0 + i));
        check("t5 fwft head", 32'(out1), 32'h0C0);
        cyc(1'b1, 1'b0, 10'h3FF);
        check_err("t5 ovf", 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_err("t5 clr ovf", 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
        check_err("t5 clr+ovf", 1'b1, 1'b0);
        check_size("t5 still full", 16);

        // 6: reset mid-stream
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, '0);
        check_size("t6 nine", 9);
        check("t6 out0", 32'(out0), 32'h0C6);
        check("t6 out1", 32'(out1), 32'h0C7);
        cyc(1'b1, 1'b1, 10'h1AB, 1'b0, 1'b0, 1'b1);
        check_size("t6 reset", 0);
        check_err("t6 reset", 1'b0, 1'b0);
        check("t6 reset out0", 32'(out0), 32'h0);
        check("t6 reset out1", 32'(out1), 32'h0);
        cyc(1'b1, 1'b0, 10'h011);
        cyc(1'b1, 1'b0, 10'h022);
        check_size("t6 two", 2);
        check("t6 fwft head", 32'(out1), 32'h011);
        cyc(1'b0, 1'b1, '0);
        check("t6 rd1 out0", 32'(out0), 32'h011);
        check("t6 rd1 out1", 32'(out1), 32'h022);
        cyc(1'b0, 1'b1, '0);
        check("t6 rd2 out0", 32'(out0), 32'h022);
        check_size("t6 end", 0);
        check_err("t6 end", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
